// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program-store loader: FSM encoding, frame defaults and
// the running checksum helper.
package prog_loader_pkg;

  localparam int          DEPTH_DEF   = 32;
  localparam int          TIMEOUT_DEF = 1024;
  localparam logic [7:0]  SYNC_DEF    = 8'hA5;

  localparam logic [2:0]  ST_IDLE     = 3'd0;
  localparam logic [2:0]  ST_LEN      = 3'd1;
  localparam logic [2:0]  ST_PAYLOAD  = 3'd2;
  localparam logic [2:0]  ST_CHK      = 3'd3;
  localparam logic [2:0]  ST_DONE     = 3'd4;
  localparam logic [2:0]  ST_ERR      = 3'd5;

  // Checksum is the plain byte sum, wrapping mod 256.
  function automatic logic [7:0] sum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

  function automatic logic in_frame(input logic [2:0] st);
    return (st == ST_LEN) || (st == ST_PAYLOAD) || (st == ST_CHK);
  endfunction

endpackage

// File: rtl/prog_loader_timer.sv
// Inter-byte idle counter: cleared on accept or outside a frame, flags after TIMEOUT-1 idle cycles.
module loader_timer
  import prog_loader_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic CPU_Clk,
  input  logic Reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [TW-1:0] timer_r;

  assign expired = (timer_r == TW'(TIMEOUT - 1));

  // Idle-cycle counter, saturating at the expiry value.
  always_ff @(posedge CPU_Clk or posedge Reset) begin
    if (Reset) begin
      timer_r <= '0;
    end else if (clr) begin
      timer_r <= '0;
    end else if (en && !expired) begin
      timer_r <= timer_r + TW'(1);
    end else begin
      timer_r <= timer_r;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Framed byte-stream parser feeding the program store; releases cpu_hold only after a
// complete frame with a good checksum.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int         DEPTH   = DEPTH_DEF,
  parameter logic [7:0] SYNC    = SYNC_DEF,
  parameter int         TIMEOUT = TIMEOUT_DEF,
  localparam int        CW      = $clog2(DEPTH) + 1
) (
  input  logic          CPU_Clk,
  input  logic          Reset,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  output logic          rx_ready,
  output logic [7:0]    fifo_data,
  output logic          fifo_wr,
  input  logic          fifo_full,
  output logic          cpu_hold,
  output logic          load_done,
  output logic          load_err,
  output logic [CW-1:0] byte_count
);

  localparam logic [7:0] MAX_LEN = 8'(DEPTH - 1);

  logic [2:0]    state_r, state_nx;
  logic [CW-1:0] len_r, len_nx;
  logic [CW-1:0] count_r, count_nx;
  logic [CW-1:0] count_inc_s;
  logic [7:0]    sum_r, sum_nx;
  logic          accept_s;
  logic          len_ok_s;
  logic          in_frame_s;
  logic          expired_s;

  assign accept_s    = rx_valid && rx_ready;
  assign len_ok_s    = (rx_data >= 8'd1) && (rx_data <= MAX_LEN);
  assign in_frame_s  = in_frame(state_r);
  assign count_inc_s = count_r + CW'(1);
  assign fifo_wr     = (state_r == ST_PAYLOAD) && rx_valid && !fifo_full;
  assign fifo_data   = rx_data;
  assign byte_count  = count_r;

  loader_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .CPU_Clk (CPU_Clk),
    .Reset   (Reset),
    .clr     (accept_s || !in_frame_s),
    .en      (in_frame_s),
    .expired (expired_s)
  );

  // Byte acceptance window per state.
  always_comb begin
    rx_ready = 1'b0;
    case (state_r)
      ST_IDLE, ST_LEN, ST_CHK: rx_ready = 1'b1;
      ST_PAYLOAD:              rx_ready = !fifo_full;
      default:                 rx_ready = 1'b0;
    endcase
  end

  // Frame parser next-state and datapath updates.
  always_comb begin
    state_nx = state_r;
    len_nx   = len_r;
    count_nx = count_r;
    sum_nx   = sum_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s && (rx_data == SYNC)) begin
          state_nx = ST_LEN;
          count_nx = '0;
          sum_nx   = 8'd0;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_LEN: begin
        if (accept_s) begin
          if (len_ok_s) begin
            len_nx   = rx_data[CW-1:0];
            state_nx = ST_PAYLOAD;
          end else begin
            state_nx = ST_ERR;
          end
        end else if (expired_s) begin
          state_nx = ST_ERR;
        end else begin
          state_nx = ST_LEN;
        end
      end
      ST_PAYLOAD: begin
        // A full store at load time means stale content; abort rather than stall.
        if (fifo_full) begin
          state_nx = ST_ERR;
        end else if (accept_s) begin
          count_nx = count_inc_s;
          sum_nx   = sum_add(sum_r, rx_data);
          state_nx = (count_inc_s == len_r) ? ST_CHK : ST_PAYLOAD;
        end else if (expired_s) begin
          state_nx = ST_ERR;
        end else begin
          state_nx = ST_PAYLOAD;
        end
      end
      ST_CHK: begin
        if (accept_s) begin
          state_nx = (rx_data == sum_r) ? ST_DONE : ST_ERR;
        end else if (expired_s) begin
          state_nx = ST_ERR;
        end else begin
          state_nx = ST_CHK;
        end
      end
      ST_DONE: state_nx = ST_DONE;
      ST_ERR:  state_nx = ST_ERR;
      default: state_nx = ST_ERR;
    endcase
  end

  // State, datapath and registered status outputs.
  always_ff @(posedge CPU_Clk or posedge Reset) begin
    if (Reset) begin
      state_r   <= ST_IDLE;
      len_r     <= '0;
      count_r   <= '0;
      sum_r     <= 8'd0;
      load_done <= 1'b0;
      load_err  <= 1'b0;
      cpu_hold  <= 1'b1;
    end else begin
      state_r   <= state_nx;
      len_r     <= len_nx;
      count_r   <= count_nx;
      sum_r     <= sum_nx;
      load_done <= (state_nx == ST_DONE);
      load_err  <= (state_nx == ST_ERR);
      cpu_hold  <= (state_nx != ST_DONE);
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: frame table plus directed corner-case sequences.
module tb_prog_loader;

  logic       CPU_Clk = 1'b0;
  logic       Reset   = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       rx_ready;
  logic [7:0] fifo_data;
  logic       fifo_wr;
  logic       fifo_full = 1'b0;
  logic       cpu_hold;
  logic       load_done;
  logic       load_err;
  logic [5:0] byte_count;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];

  always #5 CPU_Clk = ~CPU_Clk;

  prog_loader dut (
    .CPU_Clk    (CPU_Clk),
    .Reset      (Reset),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .fifo_data  (fifo_data),
    .fifo_wr    (fifo_wr),
    .fifo_full  (fifo_full),
    .cpu_hold   (cpu_hold),
    .load_done  (load_done),
    .load_err   (load_err),
    .byte_count (byte_count)
  );

  typedef struct {
    logic [71:0] frame;   // first byte in the most significant used position
    int          n;
    int          wr_start;
    int          nwr;
    logic        exp_done;
    logic        exp_err;
    logic [5:0]  exp_bc;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every store write must match the next expected payload byte.
  always @(negedge CPU_Clk) begin
    if (!Reset && fifo_wr) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_wr: got data %0h expected no write", fifo_data);
      end else begin
        chk("wr_data", {24'd0, fifo_data}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic do_reset();
    rx_valid  = 1'b0;
    fifo_full = 1'b0;
    Reset     = 1'b1;
    @(posedge CPU_Clk);
    #1;
    Reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic send(input logic [7:0] b, input logic expect_wr);
    rx_data  = b;
    rx_valid = 1'b1;
    if (expect_wr) exp_q.push_back(b);
    @(posedge CPU_Clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic check_final(input string tag, input logic done, input logic err,
                             input logic [5:0] bc);
    repeat (2) @(posedge CPU_Clk);
    #1;
    chk({tag, "_done"},  {31'd0, load_done}, {31'd0, done});
    chk({tag, "_err"},   {31'd0, load_err},  {31'd0, err});
    chk({tag, "_hold"},  {31'd0, cpu_hold},  {31'd0, !done});
    chk({tag, "_ready"}, {31'd0, rx_ready},  32'd0);
    chk({tag, "_count"}, {26'd0, byte_count}, {26'd0, bc});
    chk({tag, "_pending"}, exp_q.size(), 32'd0);
  endtask

  initial begin
    vecs[0] = '{72'h00_00_00_A5_03_11_22_33_66, 6, 2, 3, 1'b1, 1'b0, 6'd3};
    vecs[1] = '{72'h00_FF_5A_A5_03_11_22_33_66, 9, 5, 3, 1'b1, 1'b0, 6'd3};
    vecs[2] = '{72'h00_00_00_00_A5_02_10_20_31, 5, 2, 2, 1'b0, 1'b1, 6'd2};
    vecs[3] = '{72'h00_00_00_00_00_00_00_A5_00, 2, 0, 0, 1'b0, 1'b1, 6'd0};
    vecs[4] = '{72'h00_00_00_00_00_00_00_A5_20, 2, 0, 0, 1'b0, 1'b1, 6'd0};

    do_reset();
    chk("rst_hold",  {31'd0, cpu_hold},  32'd1);
    chk("rst_done",  {31'd0, load_done}, 32'd0);
    chk("rst_err",   {31'd0, load_err},  32'd0);
    chk("rst_count", {26'd0, byte_count}, 32'd0);
    chk("rst_ready", {31'd0, rx_ready},  32'd1);
    chk("rst_wr",    {31'd0, fifo_wr},   32'd0);

    for (int v = 0; v < 5; v++) begin
      do_reset();
      for (int i = 0; i < vecs[v].n; i++) begin
        send(vecs[v].frame[(vecs[v].n - 1 - i) * 8 +: 8],
             (i >= vecs[v].wr_start) && (i < vecs[v].wr_start + vecs[v].nwr));
      end
      check_final($sformatf("vec%0d", v), vecs[v].exp_done, vecs[v].exp_err, vecs[v].exp_bc);
    end

    // Longest legal frame: 31 x FF, checksum wraps to E1.
    do_reset();
    send(8'hA5, 1'b0);
    send(8'h1F, 1'b0);
    for (int i = 0; i < 31; i++) send(8'hFF, 1'b1);
    send(8'hE1, 1'b0);
    check_final("full31", 1'b1, 1'b0, 6'd31);

    // Idle timeout after one payload byte; still alive just before the limit.
    do_reset();
    send(8'hA5, 1'b0);
    send(8'h03, 1'b0);
    send(8'h11, 1'b1);
    repeat (1020) @(posedge CPU_Clk);
    #1;
    chk("tmo_early_err", {31'd0, load_err}, 32'd0);
    repeat (10) @(posedge CPU_Clk);
    #1;
    chk("tmo_err",   {31'd0, load_err}, 32'd1);
    chk("tmo_hold",  {31'd0, cpu_hold}, 32'd1);
    chk("tmo_count", {26'd0, byte_count}, 32'd1);

    // Store reported full during payload: no write, abort.
    do_reset();
    send(8'hA5, 1'b0);
    send(8'h03, 1'b0);
    send(8'h11, 1'b1);
    fifo_full = 1'b1;
    rx_data   = 8'h22;
    rx_valid  = 1'b1;
    @(negedge CPU_Clk);
    chk("full_wr",    {31'd0, fifo_wr},  32'd0);
    chk("full_ready", {31'd0, rx_ready}, 32'd0);
    @(posedge CPU_Clk);
    #1;
    rx_valid  = 1'b0;
    fifo_full = 1'b0;
    chk("full_err", {31'd0, load_err}, 32'd1);

    // Asynchronous reset in the middle of the payload.
    do_reset();
    send(8'hA5, 1'b0);
    send(8'h03, 1'b0);
    send(8'h11, 1'b1);
    Reset = 1'b1;
    #1;
    chk("mid_count", {26'd0, byte_count}, 32'd0);
    chk("mid_hold",  {31'd0, cpu_hold},  32'd1);
    chk("mid_err",   {31'd0, load_err},  32'd0);
    chk("mid_ready", {31'd0, rx_ready},  32'd1);
    chk("mid_pending", exp_q.size(), 32'd0);
    @(posedge CPU_Clk);
    #1;
    Reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
